ifetch_unit: RTL and testbench

- Instruction-fetch front end of the core. It owns the fetch PC, issues word requests to instruction memory over a valid/ready channel, and consumes in-order responses, including the PMP execute-fault flag.
- Fetched instructions are buffered and presented to decode over a valid/ready handshake.
- It handles branch/jump redirects by flushing the buffer and discarding in-flight responses.
- Each request advances the PC by 4 internally (8-bit, modulo 256).

---
 rtl/ifetch_pkg.sv | 25 ++
 rtl/ifetch_buf.sv | 65 ++++++
 rtl/ifetch_unit.sv | 130 +++++++++++++
 tb/tb_ifetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifetch_pkg;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 32;

   localparam logic [PC_W-1:0] PC_STEP  = 8'd4;
   localparam logic [PC_W-1:0] RESET_PC = 8'h00;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [INSTR_W-1:0] data;
      logic [PC_W-1:0]    pc;
      logic               fault;
   } fetch_entry_t;

   function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
      return addr & ~PC_W'(3);
   endfunction

endpackage

// File: rtl/ifetch_buf.sv
// Synchronous FIFO of fetch entries; flush empties it in one cycle.
module ifetch_buf
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [AW:0]  count,
   output logic         full,
   output logic         empty
);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop && !empty;
      // A push into a full FIFO is legal only when the head leaves in the same cycle.
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: PC, credit-limited imem requests, buffered delivery to decode.
// Define IFETCH_BYPASS_EN to forward a response straight to decode when the buffer is idle.
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter int              BUF_DEPTH = 2,
   parameter logic [PC_W-1:0] RESET_PC  = ifetch_pkg::RESET_PC
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [PC_W-1:0]    imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               imem_rsp_fault,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr_data,
   output logic [PC_W-1:0]    instr_pc,
   output logic               instr_fault
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;
   typedef logic [CW-1:0] cnt_t;

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0] rsp_pc_q, rsp_pc_d;
   logic [PC_W-1:0] redirect_tgt;
   cnt_t            outstanding_q, outstanding_d;
   cnt_t            drop_cnt_q, drop_cnt_d;
   cnt_t            buf_count;
   logic [CW:0]     credit_used;
   logic            accept, rsp_keep, bypass;
   logic            buf_push, buf_pop, buf_full, buf_empty;
   fetch_entry_t    rsp_entry, buf_head, out_entry;

   assign redirect_tgt = align_word(redirect_pc);
   assign rsp_entry    = '{data: imem_rsp_data, pc: rsp_pc_q, fault: imem_rsp_fault};

   ifetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (buf_push),
      .push_data (rsp_entry),
      .pop       (buf_pop),
      .head      (buf_head),
      .count     (buf_count),
      .full      (buf_full),
      .empty     (buf_empty)
   );

   always_comb begin
      rsp_keep = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
`ifdef IFETCH_BYPASS_EN
      bypass   = rsp_keep && buf_empty && instr_ready;
`else
      bypass   = 1'b0;
`endif
      buf_push = rsp_keep && !bypass;
      buf_pop  = !buf_empty && instr_ready && !redirect_valid;

      // An entry leaving this cycle frees its slot before any new response can land.
      credit_used    = {1'b0, outstanding_q} + {1'b0, buf_count} - (CW+1)'(buf_pop || bypass);
      imem_req_valid = !rst && (state_q == RUN) && !redirect_valid
                       && (credit_used < (CW+1)'(BUF_DEPTH));
      imem_req_addr  = fetch_pc_q;
      accept         = imem_req_valid && imem_req_ready;

      out_entry   = bypass ? rsp_entry : buf_head;
      instr_valid = !buf_empty || bypass;
      instr_pc    = instr_valid ? out_entry.pc : '0;
      instr_fault = instr_valid && out_entry.fault;
      instr_data  = (instr_valid && !out_entry.fault) ? out_entry.data : '0;

      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      outstanding_d = outstanding_q + cnt_t'(accept) - cnt_t'(imem_rsp_valid);
      drop_cnt_d    = drop_cnt_q;
      if (redirect_valid) begin
         state_d    = RUN;
         fetch_pc_d = redirect_tgt;
         rsp_pc_d   = redirect_tgt;
         drop_cnt_d = outstanding_d;
      end else begin
         if (accept) fetch_pc_d = fetch_pc_q + PC_STEP;
         if (rsp_keep) begin
            rsp_pc_d = rsp_pc_q + PC_STEP;
            // Younger fetches behind a faulting one are speculative; discard them.
            if (imem_rsp_fault) begin
               state_d    = HALT;
               drop_cnt_d = outstanding_d;
            end
         end else if (imem_rsp_valid) begin
            drop_cnt_d = drop_cnt_q - cnt_t'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= RUN;
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(imem_rsp_valid && outstanding_q == '0));
         assert (!(buf_push && buf_full && !buf_pop));
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: in-order memory model, directed fetch scenarios.
module tb_ifetch_unit;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         imem_req_valid;
   logic         imem_req_ready = 1'b1;
   logic [7:0]   imem_req_addr;
   logic         imem_rsp_valid = 1'b0;
   logic [31:0]  imem_rsp_data = '0;
   logic         imem_rsp_fault = 1'b0;
   logic         redirect_valid = 1'b0;
   logic [7:0]   redirect_pc = '0;
   logic         instr_valid;
   logic         instr_ready = 1'b0;
   logic [31:0]  instr_data;
   logic [7:0]   instr_pc;
   logic         instr_fault;

   ifetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_fault (imem_rsp_fault),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc),
      .instr_fault    (instr_fault)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   function automatic logic [31:0] mem_word(input logic [7:0] a);
      return 32'hC0DE_0000 | {24'h0, a};
   endfunction

   // Memory model: in-order responses, lat cycles after accept, reset with the DUT.
   int         lat = 1;
   logic       fault_en = 1'b0;
   logic [7:0] fault_addr = 8'h10;
   logic [7:0] pend_addr[$];
   int         pend_due[$];
   logic [7:0] acc_log[$];

   always @(posedge clk) begin
      if (rst) begin
         pend_addr.delete();
         pend_due.delete();
      end else if (imem_req_valid && imem_req_ready) begin
         pend_addr.push_back(imem_req_addr);
         pend_due.push_back(cyc + lat);
         acc_log.push_back(imem_req_addr);
      end
      #2;
      if (!rst && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(pend_addr[0]);
         imem_rsp_fault = fault_en && (pend_addr[0] == fault_addr);
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
         imem_rsp_fault = 1'b0;
      end
   end

   logic [40:0] exp_q[$];
   int          pop_cyc[$];
   logic [40:0] mon_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] pc, input logic f);
      exp_q.push_back({pc, (f ? 32'h0 : mem_word(pc)), f});
   endtask

   task automatic redirect_to(input logic [7:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      tick();
      redirect_valid = 1'b0;
      redirect_pc    = '0;
   endtask

   task automatic drain(input string name);
      int budget = 200;
      instr_ready = 1'b1;
      while (exp_q.size() > 0 && budget > 0) begin
         tick();
         budget--;
      end
      instr_ready = 1'b0;
      check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      int mark;
      int n;
      logic [7:0] wrap_a[4];
      wrap_a = '{8'hF8, 8'hFC, 8'h00, 8'h04};
      fork
         begin : monitor
            forever begin
               @(negedge clk);
               if (!rst && instr_valid && instr_ready) begin
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_instr: got pc=%0h data=%0h fault=%0b, required no delivery",
                              instr_pc, instr_data, instr_fault);
                  end else begin
                     mon_e = exp_q.pop_front();
                     check("instr_pc", 64'(instr_pc), 64'(mon_e[40:33]));
                     check("instr_data", 64'(instr_data), 64'(mon_e[32:1]));
                     check("instr_fault", 64'(instr_fault), 64'(mon_e[0]));
                  end
                  pop_cyc.push_back(cyc);
               end
            end
         end
         begin : watchdog
            repeat (20000) @(posedge clk);
            errors++;
            $display("FAIL watchdog: got timeout, required completion");
         end
         begin : stimulus
            // Reset values
            tick();
            tick();
            @(negedge clk);
            check("rst_req_valid", 64'(imem_req_valid), 64'd0);
            check("rst_instr_valid", 64'(instr_valid), 64'd0);
            check("rst_instr_data", 64'(instr_data), 64'd0);
            check("rst_instr_pc", 64'(instr_pc), 64'd0);
            check("rst_instr_fault", 64'(instr_fault), 64'd0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            check("post_rst_req_valid", 64'(imem_req_valid), 64'd1);
            check("post_rst_req_addr", 64'(imem_req_addr), 64'h00);
            tick();

            // Streaming from reset
            mark = 0;
            for (int i = 0; i < 8; i++) push_exp(8'(i * 4), 1'b0);
            drain("stream");
            n = pop_cyc.size();
            check("stream_no_gap", 64'(pop_cyc[n-1] - pop_cyc[n-8]), 64'd7);
            for (int i = 0; i < 8; i++) check("stream_req_addr", 64'(acc_log[mark+i]), 64'(i * 4));

            // Wrap-around
            mark = acc_log.size();
            for (int i = 0; i < 4; i++) push_exp(wrap_a[i], 1'b0);
            redirect_to(8'hF8);
            drain("wrap");
            for (int i = 0; i < 4; i++) check("wrap_req_addr", 64'(acc_log[mark+i]), 64'(wrap_a[i]));

            // Backpressure
            mark = acc_log.size();
            push_exp(8'h30, 1'b0);
            push_exp(8'h34, 1'b0);
            push_exp(8'h38, 1'b0);
            push_exp(8'h3C, 1'b0);
            redirect_to(8'h30);
            repeat (10) tick();
            @(negedge clk);
            check("bp_req_valid", 64'(imem_req_valid), 64'd0);
            check("bp_accepts", 64'(acc_log.size() - mark), 64'd2);
            check("bp_instr_valid", 64'(instr_valid), 64'd1);
            tick();
            drain("backpressure");
            for (int i = 0; i < 4; i++) check("bp_req_addr", 64'(acc_log[mark+i]), 64'(8'h30 + i * 4));

            // Redirect with two responses in flight
            lat = 3;
            mark = acc_log.size();
            redirect_to(8'h50);
            tick();
            tick();
            check("inflight_accepts", 64'(acc_log.size() - mark), 64'd2);
            push_exp(8'h40, 1'b0);
            push_exp(8'h44, 1'b0);
            mark = acc_log.size();
            redirect_to(8'h43);
            drain("redirect_drop");
            lat = 1;
            check("redir_req_addr0", 64'(acc_log[mark]), 64'h40);
            check("redir_req_addr1", 64'(acc_log[mark+1]), 64'h44);

            // PMP fault at 0x10, then resume at 0x80
            fault_en = 1'b1;
            mark = acc_log.size();
            push_exp(8'h08, 1'b0);
            push_exp(8'h0C, 1'b0);
            push_exp(8'h10, 1'b1);
            redirect_to(8'h08);
            drain("fault");
            n = acc_log.size();
            instr_ready = 1'b1;
            repeat (8) tick();
            @(negedge clk);
            check("halt_req_valid", 64'(imem_req_valid), 64'd0);
            check("halt_instr_valid", 64'(instr_valid), 64'd0);
            check("halt_no_new_accepts", 64'(acc_log.size() - n), 64'd0);
            check("fault_first_addr", 64'(acc_log[mark]), 64'h08);
            tick();
            instr_ready = 1'b0;
            fault_en = 1'b0;
            mark = acc_log.size();
            push_exp(8'h80, 1'b0);
            push_exp(8'h84, 1'b0);
            push_exp(8'h88, 1'b0);
            redirect_to(8'h80);
            drain("resume");
            check("resume_req_addr", 64'(acc_log[mark]), 64'h80);

            // Reset with one response buffered and one outstanding
            lat = 3;
            redirect_to(8'h20);
            repeat (4) tick();
            @(negedge clk);
            check("pre_rst_instr_valid", 64'(instr_valid), 64'd1);
            check("pre_rst_instr_pc", 64'(instr_pc), 64'h20);
            rst = 1'b1;
            tick();
            @(negedge clk);
            check("midrst_req_valid", 64'(imem_req_valid), 64'd0);
            check("midrst_instr_valid", 64'(instr_valid), 64'd0);
            check("midrst_instr_data", 64'(instr_data), 64'd0);
            check("midrst_instr_pc", 64'(instr_pc), 64'd0);
            check("midrst_instr_fault", 64'(instr_fault), 64'd0);
            tick();
            rst = 1'b0;
            lat = 1;
            mark = acc_log.size();
            push_exp(8'h00, 1'b0);
            push_exp(8'h04, 1'b0);
            drain("after_reset");
            check("after_rst_req_addr", 64'(acc_log[mark]), 64'h00);
         end
      join_any
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
